// File: rtl/alu_operand_stage.sv
// Operand-select stage in front of the ALU: result bypass, operand muxing,
// funct7 sanitising and a 2-entry skid buffer toward the ALU.
module alu_operand_stage #(
  parameter int WORDSIZE = 64,
  parameter int REGADDR  = 5
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [REGADDR-1:0]  rs1_addr,
  input  logic [REGADDR-1:0]  rs2_addr,
  input  logic [WORDSIZE-1:0] rs1_data,
  input  logic [WORDSIZE-1:0] rs2_data,
  input  logic [WORDSIZE-1:0] imm,
  input  logic [WORDSIZE-1:0] pc,
  input  logic                use_imm,
  input  logic                use_pc,
  input  logic [2:0]          in_funct3,
  input  logic [6:0]          in_funct7,
  input  logic [3:0]          in_alu_cmd,
  input  logic [REGADDR-1:0]  in_rd,
  input  logic                fwd_valid,
  input  logic [REGADDR-1:0]  fwd_rd,
  input  logic [WORDSIZE-1:0] fwd_data,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WORDSIZE-1:0] input_a,
  output logic [WORDSIZE-1:0] input_b,
  output logic [2:0]          funct3,
  output logic [6:0]          funct7,
  output logic [3:0]          alu_cmd,
  output logic [REGADDR-1:0]  rd
);

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_t;

  typedef struct packed {
    logic [WORDSIZE-1:0] a;
    logic [WORDSIZE-1:0] b;
    logic [2:0]          f3;
    logic [6:0]          f7;
    logic [3:0]          cmd;
    logic [REGADDR-1:0]  rd;
  } entry_t;

  state_t state_q, state_d;
  entry_t main_q, skid_q, cap;
  logic   in_ready_q;
  logic   accept;
  logic   load_main_cap, load_main_skid, load_skid;
  logic   rs1_hit, rs2_hit;

  assign accept = in_valid && in_ready_q && !flush;

  // Capture path: bypass (never for x0), operand select, funct7 sanitising.
  // Shift-immediates (funct3 101) keep funct7 so SRAI/SRLI stay distinct.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    cap     = '0;
    rs1_hit = fwd_valid && (fwd_rd == rs1_addr) && (rs1_addr != '0);
    rs2_hit = fwd_valid && (fwd_rd == rs2_addr) && (rs2_addr != '0);
    cap.a   = use_pc  ? pc  : (rs1_hit ? fwd_data : rs1_data);
    cap.b   = use_imm ? imm : (rs2_hit ? fwd_data : rs2_data);
    cap.f3  = in_funct3;
    cap.f7  = (use_imm && (in_funct3 != 3'b101)) ? 7'b0000000 : in_funct7;
    cap.cmd = in_alu_cmd;
    cap.rd  = in_rd;
  end

  // Flush dominates; data registers are only steered, never cleared by it.
  always_comb begin
    state_d        = state_q;
    load_main_cap  = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      unique case (state_q)
        S_EMPTY: begin
          if (accept) begin
            state_d       = S_ONE;
            load_main_cap = 1'b1;
          end
        end
        S_ONE: begin
          if (accept && out_ready) begin
            load_main_cap = 1'b1;
          end else if (accept) begin
            state_d   = S_FULL;
            load_skid = 1'b1;
          end else if (out_ready) begin
            state_d = S_EMPTY;
          end
        end
        S_FULL: begin
          if (out_ready) begin
            state_d        = S_ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_EMPTY;
      in_ready_q <= 1'b1;
      // NOTE: the entry registers are reset because they drive the ALU ports,
      // which must read zero after reset.
      main_q     <= '0;
      skid_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      in_ready_q <= (state_d != S_FULL);
      if (load_main_cap)       main_q <= cap;
      else if (load_main_skid) main_q <= skid_q;
      if (load_skid)           skid_q <= cap;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != S_EMPTY);
  assign input_a   = main_q.a;
  assign input_b   = main_q.b;
  assign funct3    = main_q.f3;
  assign funct7    = main_q.f7;
  assign alu_cmd   = main_q.cmd;
  assign rd        = main_q.rd;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: directed plan steps followed by
// a randomized run, checked against a queue-based reference model.
module tb_alu_operand_stage;

  logic        clk;
  logic        reset_n;
  logic        in_valid, in_ready;
  logic [4:0]  rs1_addr, rs2_addr, in_rd, fwd_rd, rd;
  logic [63:0] rs1_data, rs2_data, imm, pc, fwd_data, input_a, input_b;
  logic        use_imm, use_pc, fwd_valid, flush, out_valid, out_ready;
  logic [2:0]  in_funct3, funct3;
  logic [6:0]  in_funct7, funct7;
  logic [3:0]  in_alu_cmd, alu_cmd;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [3:0]  cmd;
    logic [4:0]  rd;
  } ent_t;

  ent_t q[$];

  alu_operand_stage dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .imm(imm), .pc(pc), .use_imm(use_imm), .use_pc(use_pc),
    .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_alu_cmd(in_alu_cmd), .in_rd(in_rd),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .input_a(input_a), .input_b(input_b),
    .funct3(funct3), .funct7(funct7), .alu_cmd(alu_cmd), .rd(rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // What the ALU should see for the instruction currently offered.
  function automatic ent_t ref_entry();
    ent_t e;
    logic [63:0] r1, r2;
    r1 = (fwd_valid && fwd_rd == rs1_addr && rs1_addr != 0) ? fwd_data : rs1_data;
    r2 = (fwd_valid && fwd_rd == rs2_addr && rs2_addr != 0) ? fwd_data : rs2_data;
    e.a   = use_pc ? pc : r1;
    e.b   = use_imm ? imm : r2;
    e.f3  = in_funct3;
    e.f7  = (use_imm && in_funct3 != 3'b101) ? 7'd0 : in_funct7;
    e.cmd = in_alu_cmd;
    e.rd  = in_rd;
    return e;
  endfunction

  task automatic check_state();
    check("out_valid", {63'd0, out_valid}, {63'd0, q.size() > 0});
    check("in_ready",  {63'd0, in_ready},  {63'd0, q.size() < 2});
    if (q.size() > 0) begin
      check("input_a", input_a, q[0].a);
      check("input_b", input_b, q[0].b);
      check("funct3",  {61'd0, funct3},  {61'd0, q[0].f3});
      check("funct7",  {57'd0, funct7},  {57'd0, q[0].f7});
      check("alu_cmd", {60'd0, alu_cmd}, {60'd0, q[0].cmd});
      check("rd",      {59'd0, rd},      {59'd0, q[0].rd});
    end
  endtask

  // One clock: model update on the edge from the held inputs, check at negedge.
  task automatic cycle();
    ent_t e;
    bit   acc;
    @(posedge clk);
    acc = in_valid && (q.size() < 2) && !flush;
    e   = ref_entry();
    if (flush) begin
      q.delete();
    end else begin
      if (out_ready && q.size() > 0) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    @(negedge clk);
    check_state();
  endtask

  task automatic idle_inputs();
    in_valid = 0; rs1_addr = 0; rs2_addr = 0; rs1_data = 0; rs2_data = 0;
    imm = 0; pc = 0; use_imm = 0; use_pc = 0; in_funct3 = 0; in_funct7 = 0;
    in_alu_cmd = 0; in_rd = 0; fwd_valid = 0; fwd_rd = 0; fwd_data = 0;
    flush = 0; out_ready = 1;
  endtask

  task automatic offer_r(input logic [63:0] a, input logic [63:0] b, input logic [4:0] d);
    in_valid = 1; use_imm = 0; use_pc = 0; fwd_valid = 0;
    rs1_addr = 5'd1; rs2_addr = 5'd2; rs1_data = a; rs2_data = b;
    in_funct3 = 0; in_funct7 = 0; in_alu_cmd = 4'd0; in_rd = d;
  endtask

  initial begin
    idle_inputs();
    reset_n = 0;

    // 1. Reset state, then a plain R-type add.
    @(negedge clk);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_in_ready",  {63'd0, in_ready},  64'd1);
    check("rst_input_a", input_a, 64'd0);
    check("rst_input_b", input_b, 64'd0);
    check("rst_fields", {45'd0, funct3, funct7, alu_cmd, rd}, 64'd0);
    reset_n = 1;
    offer_r(64'd5, 64'd7, 5'd10);
    cycle();
    check("add_a", input_a, 64'd5);
    check("add_b", input_b, 64'd7);
    check("add_valid", {63'd0, out_valid}, 64'd1);

    // 2. ADDI clears funct7; SRAI keeps it.
    use_imm = 1; imm = 64'hFFFF_FFFF_FFFF_FFE0; in_funct3 = 3'b000; in_funct7 = 7'b1111111;
    cycle();
    check("addi_b", input_b, 64'hFFFF_FFFF_FFFF_FFE0);
    check("addi_f7", {57'd0, funct7}, 64'd0);
    in_funct3 = 3'b101; in_funct7 = 7'b0100000;
    cycle();
    check("srai_f7", {57'd0, funct7}, 64'h20);

    // 3. Bypass on rs1, and no bypass of x0.
    use_imm = 0; fwd_valid = 1; fwd_rd = 5'd3; fwd_data = 64'd99;
    rs1_addr = 5'd3; rs1_data = 64'd1; in_funct3 = 0; in_funct7 = 0;
    cycle();
    check("fwd_a", input_a, 64'd99);
    rs1_addr = 5'd0; fwd_rd = 5'd0;
    cycle();
    check("fwd_x0_a", input_a, 64'd1);
    in_valid = 0; fwd_valid = 0;
    cycle();

    // 4. Back-pressure: A presented, B to skid, C held upstream.
    offer_r(64'hA, 64'hA0, 5'd1);
    cycle();
    offer_r(64'hB, 64'hB0, 5'd2); out_ready = 0;
    cycle();
    check("bp_in_ready", {63'd0, in_ready}, 64'd0);
    check("bp_hold_a1", input_a, 64'hA);
    offer_r(64'hC, 64'hC0, 5'd3);
    cycle();
    check("bp_hold_a2", input_a, 64'hA);
    out_ready = 1;
    cycle();
    check("bp_drain_b", input_a, 64'hB);
    cycle();
    check("bp_drain_c", input_a, 64'hC);
    in_valid = 0;
    cycle();
    check("bp_empty", {63'd0, out_valid}, 64'd0);

    // 5. Flush from FULL with input offered and out_ready high.
    offer_r(64'h11, 64'h12, 5'd4);
    cycle();
    offer_r(64'h21, 64'h22, 5'd5); out_ready = 0;
    cycle();
    offer_r(64'h31, 64'h32, 5'd6); flush = 1; out_ready = 1;
    cycle();
    check("flush_valid", {63'd0, out_valid}, 64'd0);
    check("flush_ready", {63'd0, in_ready}, 64'd1);
    flush = 0; in_valid = 0;
    cycle();
    check("flush_no_ghost", {63'd0, out_valid}, 64'd0);

    // 6. Asynchronous reset from FULL, between edges.
    offer_r(64'h41, 64'h42, 5'd7);
    cycle();
    offer_r(64'h51, 64'h52, 5'd8); out_ready = 0;
    cycle();
    #2 reset_n = 0;
    #1;
    check("arst_out_valid", {63'd0, out_valid}, 64'd0);
    check("arst_in_ready",  {63'd0, in_ready},  64'd1);
    check("arst_input_a", input_a, 64'd0);
    q.delete();
    idle_inputs();
    @(negedge clk);
    reset_n = 1;

    // Randomized run against the queue model.
    for (int i = 0; i < 600; i++) begin
      in_valid   = ($urandom_range(0, 9) < 7);
      out_ready  = ($urandom_range(0, 9) < 6);
      flush      = ($urandom_range(0, 19) == 0);
      rs1_addr   = 5'($urandom_range(0, 3));
      rs2_addr   = 5'($urandom_range(0, 3));
      rs1_data   = {$urandom, $urandom};
      rs2_data   = {$urandom, $urandom};
      imm        = {$urandom, $urandom};
      pc         = {$urandom, $urandom};
      use_imm    = 1'($urandom);
      use_pc     = 1'($urandom);
      in_funct3  = 3'($urandom);
      in_funct7  = 7'($urandom);
      in_alu_cmd = 4'($urandom);
      in_rd      = 5'($urandom);
      fwd_valid  = 1'($urandom);
      fwd_rd     = 5'($urandom_range(0, 3));
      fwd_data   = {$urandom, $urandom};
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
